gray_ptr_sync_decoder: RTL and testbench
========================================

// Module: gray_ptr_sync_decoder
// PURPOSE
//   Receive side of the gray-coded counter path. Takes a gray-coded counter
//   value from a remote bin_to_gray encoder and resynchronises it through a
//   flop chain. Decodes it back to binary and reports the increment since the
//   last sample. Flags illegal multi-bit gray steps. Sits on the consumer side
//   of pointer/counter crossings, for example async FIFO read/write pointer
//   compare logic.
// PARAMETERS
//   CNTR_WIDTH   8   width of gray input and all binary outputs (>=2)
//   SYNC_STAGES  2   synchroniser flops on gray_i (>=2)
// PORTS
//   clk           input   1           sampling clock, rising edge
//   reset         input   1           async reset, active-low (0 = in reset)
//   gray_i        input   CNTR_WIDTH  gray-coded counter, may be asynchronous to clk
//   clr_err_i     input   1           clears err_sticky_o
//   bin_o         output  CNTR_WIDTH  decoded binary counter value
//   bin_valid_o   output  1           bin_o/delta_o are meaningful
//   delta_o       output  CNTR_WIDTH  bin_o minus previous bin_o, modulo 2^CNTR_WIDTH
//   step_err_o    output  1           1-cycle pulse: >1 gray bit changed between samples
//   err_sticky_o  output  1           latched step error
// BEHAVIOUR
//   - reset=0: all sync flops, bin_o, delta_o, bin_valid_o, step_err_o and
//     err_sticky_o are cleared to 0 immediately, without waiting for clk.
//   - Sync chain: gray_i -> SYNC_STAGES flops. Output of the last flop is g_s.
//   - Decode stage (registered):
//     * bin_o <= gray2bin(g_s), where b[W-1]=g[W-1] and b[i]=b[i+1]^g[i].
//     * Latency gray_i -> bin_o is SYNC_STAGES+1 clk.
//   - The decode stage also holds g_prev, the g_s value decoded on the previous cycle.
//   - bin_valid_o:
//     * A warm-up counter of SYNC_STAGES+1 cycles starts at reset release.
//     * bin_valid_o rises when it expires and then stays 1 until reset.
//   - delta_o:
//     * delta_o <= gray2bin(g_s) - bin_o, truncated to CNTR_WIDTH. Wrap 255->0 gives 1.
//     * Forced 0 while bin_valid_o=0 and on the first valid cycle.
//   - step_err_o:
//     * Asserted for one cycle when popcount(g_s ^ g_prev) > 1 and bin_valid_o was already 1.
//     * This check is bit-count only; a legal single-bit step may still decode
//       to a jump >1 (for example 0x00 -> 0x04 decodes 0 -> 7).
//     * bin_o and delta_o still update on an errored sample. No hold, no correction.
//   - err_sticky_o:
//     * Set by step_err_o and cleared by clr_err_i.
//     * If both happen in the same cycle, set wins and err_sticky_o stays 1.
//   - Constant input: bin_o is held, delta_o=0, no error.
//   - Reset mid-operation: the async clear applies. After release the full
//     SYNC_STAGES+1 warm-up repeats before bin_valid_o=1.
//   - No flow control. gray_i must change at most once per clk period at the
//     source; faster changes surface as step_err_o.
// STRUCTURE
//   - gray_pkg (shared with bin_to_gray):
//     * functions bin2gray(), gray2bin(), popcount()
//     * localparam default CNTR_WIDTH
//   - Sub-module gray_to_bin: combinational decoder, parameterised by
//     CNTR_WIDTH, instantiated once.
//   - Sync chain, warm-up counter, delta/error logic stay in this module.
// TESTING   (CNTR_WIDTH=8, SYNC_STAGES=2)
//   1. Reset hold, gray_i=0x00 -> all outputs 0. Release -> bin_valid_o=1 on the
//      3rd rising clk edge; delta_o=0, step_err_o=0 on that cycle.
//   2. Drive bin2gray(0..255,0), one value per clk -> bin_o follows 3 clk later.
//      delta_o=1 every cycle including the 255->0 wrap. step_err_o never asserts.
//   3. Hold gray_i=0x0C -> bin_o=0x08, delta_o=0 every cycle, no error.
//   4. gray_i 0x00 -> 0x03 in one clk -> bin_o=0x02, delta_o=2, step_err_o high
//      for exactly 1 clk, err_sticky_o=1. Pulse clr_err_i -> err_sticky_o=0.
//      Repeat with clr_err_i on the error cycle -> err_sticky_o stays 1.
//   5. Single-bit step 0x00 -> 0x04 -> bin_o=0x07, delta_o=7, no step_err_o.
//   6. While counting (bin_o=100), pull reset low between clk edges -> outputs
//      0 before the next edge. Release -> bin_valid_o reasserts 3 clk later with delta_o=0.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared gray-code helpers used by both the encoder (bin_to_gray) and the
// receive-side decoder. Functions work on 32-bit containers; narrower
// counters are zero-extended, which leaves the results unchanged.
package gray_pkg;

    localparam int DEFAULT_CNTR_WIDTH = 8;

    // Binary to reflected gray code.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reflected gray code back to binary: b[i] = b[i+1] ^ g[i].
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

    // Number of set bits.
    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + 6'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/gray_ptr_sync_decoder_if.sv
// Bundle between the gray-counter consumer and the decoder: the incoming
// gray value and error clear, plus the decoded results.
interface gray_ptr_sync_decoder_if
    import gray_pkg::*;
#(
    parameter int CNTR_WIDTH = DEFAULT_CNTR_WIDTH
);

    logic [CNTR_WIDTH-1:0] gray_i;
    logic                  clr_err_i;
    logic [CNTR_WIDTH-1:0] bin_o;
    logic                  bin_valid_o;
    logic [CNTR_WIDTH-1:0] delta_o;
    logic                  step_err_o;
    logic                  err_sticky_o;

    // Side that supplies the gray value and consumes the decoded results.
    modport master (
        output gray_i,
        output clr_err_i,
        input  bin_o,
        input  bin_valid_o,
        input  delta_o,
        input  step_err_o,
        input  err_sticky_o
    );

    // Decoder side.
    modport slave (
        input  gray_i,
        input  clr_err_i,
        output bin_o,
        output bin_valid_o,
        output delta_o,
        output step_err_o,
        output err_sticky_o
    );

endinterface

// File: rtl/gray_to_bin.sv
// Combinational gray-to-binary decoder. Each binary bit is the XOR of all
// gray bits at or above it, written as independent reductions so there is
// no bit-to-bit combinational chain inside one vector.
module gray_to_bin
    import gray_pkg::*;
#(
    parameter int CNTR_WIDTH = DEFAULT_CNTR_WIDTH
) (
    input  logic [CNTR_WIDTH-1:0] gray,
    output logic [CNTR_WIDTH-1:0] bin
);

    genvar gi;
    generate
        for (gi = 0; gi < CNTR_WIDTH; gi++) begin : g_bit
            assign bin[gi] = ^gray[CNTR_WIDTH-1:gi];
        end
    endgenerate

endmodule

// File: rtl/gray_ptr_sync_decoder.sv
// Receive side of a gray-coded counter crossing: resynchronise the gray
// value through a flop chain, decode to binary, report the increment since
// the previous sample and flag samples where more than one gray bit moved.
module gray_ptr_sync_decoder
    import gray_pkg::*;
#(
    parameter int CNTR_WIDTH  = DEFAULT_CNTR_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    gray_ptr_sync_decoder_if.slave  bus
);

    // Warm-up counter only needs to reach SYNC_STAGES.
    localparam int WU_W = $clog2(SYNC_STAGES + 1) + 1;

    logic [SYNC_STAGES-1:0][CNTR_WIDTH-1:0] sync_reg;
    logic [SYNC_STAGES-1:0][CNTR_WIDTH-1:0] sync_next;
    logic [CNTR_WIDTH-1:0] g_s;
    logic [CNTR_WIDTH-1:0] dec_bin;

    logic [CNTR_WIDTH-1:0] bin_reg,    bin_next;
    logic [CNTR_WIDTH-1:0] g_prev_reg, g_prev_next;
    logic [CNTR_WIDTH-1:0] delta_reg,  delta_next;
    logic                  valid_reg,  valid_next;
    logic                  err_reg,    err_next;
    logic                  sticky_reg, sticky_next;
    logic [WU_W-1:0]       wcnt_reg,   wcnt_next;

    // Shift structure of the synchroniser: stage 0 takes the raw input,
    // every later stage takes its predecessor.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = bus.gray_i;
            end else begin : g_rest
                assign sync_next[gi] = sync_reg[gi - 1];
            end
        end
    endgenerate

    assign g_s = sync_reg[SYNC_STAGES-1];

    gray_to_bin #(
        .CNTR_WIDTH (CNTR_WIDTH)
    ) u_gray_to_bin (
        .gray (g_s),
        .bin  (dec_bin)
    );

    // Next-state for the decode stage, warm-up and error tracking.
    always_comb begin
        wcnt_next   = wcnt_reg;
        if (!valid_reg) begin
            wcnt_next = wcnt_reg + WU_W'(1);
        end
        valid_next  = valid_reg | (wcnt_reg == WU_W'(SYNC_STAGES));
        bin_next    = dec_bin;
        g_prev_next = g_s;
        // The first valid cycle still compares against a pre-valid bin_reg,
        // so delta only becomes live once valid was already high.
        delta_next  = valid_reg ? (dec_bin - bin_reg) : '0;
        // Bit-count check only; a legal one-bit step can still decode to a
        // large binary jump.
        err_next    = valid_reg && (popcount(32'(g_s ^ g_prev_reg)) > 6'd1);
        // A new error wins over a simultaneous clear.
        sticky_next = err_next | (sticky_reg & ~bus.clr_err_i);
    end

    // State registers; reset clears everything without waiting for clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg   <= '0;
            bin_reg    <= '0;
            g_prev_reg <= '0;
            delta_reg  <= '0;
            valid_reg  <= 1'b0;
            err_reg    <= 1'b0;
            sticky_reg <= 1'b0;
            wcnt_reg   <= '0;
        end else begin
            sync_reg   <= sync_next;
            bin_reg    <= bin_next;
            g_prev_reg <= g_prev_next;
            delta_reg  <= delta_next;
            valid_reg  <= valid_next;
            err_reg    <= err_next;
            sticky_reg <= sticky_next;
            wcnt_reg   <= wcnt_next;
        end
    end

    assign bus.bin_o        = bin_reg;
    assign bus.bin_valid_o  = valid_reg;
    assign bus.delta_o      = delta_reg;
    assign bus.step_err_o   = err_reg;
    assign bus.err_sticky_o = sticky_reg;

endmodule

// File: tb/tb_gray_ptr_sync_decoder.sv
// Directed bench for gray_ptr_sync_decoder (CNTR_WIDTH=8, SYNC_STAGES=2).
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, well away from the next edge.
module tb_gray_ptr_sync_decoder;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    gray_ptr_sync_decoder_if #(.CNTR_WIDTH(8)) bus ();

    gray_ptr_sync_decoder #(
        .CNTR_WIDTH  (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    function automatic logic [7:0] g(input int v);
        logic [7:0] b;
        b = v[7:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] e_bin, input logic e_valid,
                           input logic [7:0] e_delta, input logic e_err, input logic e_sticky);
        $display("txn %s: gray_i=%02h bin=%02h valid=%0b delta=%02h err=%0b sticky=%0b",
                 tag, bus.gray_i, bus.bin_o, bus.bin_valid_o, bus.delta_o,
                 bus.step_err_o, bus.err_sticky_o);
        chk({tag, ".bin"},    32'(bus.bin_o),        32'(e_bin));
        chk({tag, ".valid"},  32'(bus.bin_valid_o),  32'(e_valid));
        chk({tag, ".delta"},  32'(bus.delta_o),      32'(e_delta));
        chk({tag, ".err"},    32'(bus.step_err_o),   32'(e_err));
        chk({tag, ".sticky"}, 32'(bus.err_sticky_o), 32'(e_sticky));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller has reset low; hold two edges, release, then expect valid on
    // the third edge after release with the given decoded value.
    task automatic warmup(input string tag, input logic [7:0] e_bin);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk({tag, ".wu1.valid"}, 32'(bus.bin_valid_o), 32'd0);
        tick();
        chk({tag, ".wu2.valid"}, 32'(bus.bin_valid_o), 32'd0);
        tick();
        chk_out({tag, ".wu3"}, e_bin, 1'b1, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic reset_cycle(input string tag, input logic [7:0] gv, input logic [7:0] e_bin);
        bus.gray_i    = gv;
        bus.clr_err_i = 1'b0;
        reset = 1'b0;
        #2;
        chk_out({tag, ".rst"}, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        warmup(tag, e_bin);
    endtask

    initial begin
        bus.gray_i    = 8'h00;
        bus.clr_err_i = 1'b0;
        @(posedge clk);
        #1;

        // 1. Reset and warm-up with gray_i = 0.
        reset_cycle("t1", 8'h00, 8'h00);

        // 2. Full count 1..255 then wrap to 0; bin trails the input by two
        //    loop iterations, delta is 1 throughout including 255->0.
        for (int j = 0; j < 258; j++) begin
            if (j < 256) bus.gray_i = g((j + 1) & 255);
            tick();
            if (j >= 2) begin
                chk($sformatf("t2.bin[%0d]", j),   32'(bus.bin_o),      32'((j - 1) & 255));
                chk($sformatf("t2.delta[%0d]", j), 32'(bus.delta_o),    32'd1);
                chk($sformatf("t2.err[%0d]", j),   32'(bus.step_err_o), 32'd0);
            end
        end
        chk_out("t2.end", 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);

        // 3. Constant 0x0C decodes to 0x08 with zero delta and no error.
        reset_cycle("t3", 8'h0C, 8'h08);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_out($sformatf("t3.hold%0d", k), 8'h08, 1'b1, 8'h00, 1'b0, 1'b0);
        end

        // 4. Two-bit step 0x00 -> 0x03, then clear, then clear on error cycle.
        reset_cycle("t4", 8'h00, 8'h00);
        bus.gray_i = 8'h03;
        tick();
        tick();
        tick();
        chk_out("t4.step", 8'h02, 1'b1, 8'h02, 1'b1, 1'b1);
        tick();
        chk_out("t4.after", 8'h02, 1'b1, 8'h00, 1'b0, 1'b1);
        bus.clr_err_i = 1'b1;
        tick();
        bus.clr_err_i = 1'b0;
        chk_out("t4.clr", 8'h02, 1'b1, 8'h00, 1'b0, 1'b0);
        bus.gray_i = 8'h00;
        tick();
        tick();
        bus.clr_err_i = 1'b1;
        tick();
        bus.clr_err_i = 1'b0;
        chk_out("t4.setwins", 8'h00, 1'b1, 8'hFE, 1'b1, 1'b1);
        tick();
        chk_out("t4.held", 8'h00, 1'b1, 8'h00, 1'b0, 1'b1);
        bus.clr_err_i = 1'b1;
        tick();
        bus.clr_err_i = 1'b0;
        chk_out("t4.clr2", 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);

        // 5. Legal single-bit step 0x00 -> 0x04 decodes 0 -> 7.
        bus.gray_i = 8'h04;
        tick();
        tick();
        tick();
        chk_out("t5.jump", 8'h07, 1'b1, 8'h07, 1'b0, 1'b0);
        tick();
        chk_out("t5.hold", 8'h07, 1'b1, 8'h00, 1'b0, 1'b0);

        // 6. Count 8..100, then async reset between edges and re-warm-up.
        for (int v = 8; v <= 100; v++) begin
            bus.gray_i = g(v);
            tick();
        end
        tick();
        tick();
        chk_out("t6.count", 8'd100, 1'b1, 8'h01, 1'b0, 1'b0);
        #3;
        reset = 1'b0;
        #1;
        chk_out("t6.async", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        warmup("t6", 8'd100);
        tick();
        chk_out("t6.steady", 8'd100, 1'b1, 8'h00, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
